// File: rtl/seg7_mmio_ctrl.sv
// seg7_mmio_ctrl: memory-mapped, multiplexed seven-segment display controller.
// The register block sits on the data-memory port. Each digit is scanned as
// GUARD (all anodes off) followed by SHOW (one anode on). The display reads
// only shadow copies of DATA/CTRL. Those copies reload at the start of each
// frame, so a frame never shows a mix of old and new values.
module seg7_mmio_ctrl #(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned REFRESH_DIV  = 262144,
  parameter int unsigned GUARD_CYCLES = 16,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0100
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we,
  input  logic [31:0]           addr,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata,
  output logic                  sel,
  output logic [NUM_DIGITS-1:0] an,
  output logic [6:0]            seg,
  output logic                  dp
);

  localparam int unsigned DATA_W = 4 * NUM_DIGITS;
  localparam int unsigned IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  // The largest count is REFRESH_DIV-GUARD_CYCLES-1, which is below REFRESH_DIV.
  localparam int unsigned CNT_W  = $clog2(REFRESH_DIV);

  localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD_CYCLES - 1);
  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(REFRESH_DIV - GUARD_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

  typedef enum logic {
    ST_GUARD = 1'b0,
    ST_SHOW  = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    REG_DATA   = 2'd0,
    REG_CTRL   = 2'd1,
    REG_STATUS = 2'd2,
    REG_RSVD   = 2'd3
  } reg_e;

  // Live registers, written from the bus.
  logic [DATA_W-1:0]     data_q, data_d;
  logic                  en_q, en_d;
  logic [NUM_DIGITS-1:0] dp_mask_q, dp_mask_d;
  logic [NUM_DIGITS-1:0] blank_q, blank_d;

  // Frame shadows, which are the only values the display uses.
  logic [DATA_W-1:0]     data_sh_q, data_sh_d;
  logic                  en_sh_q, en_sh_d;
  logic [NUM_DIGITS-1:0] dp_sh_q, dp_sh_d;
  logic [NUM_DIGITS-1:0] blank_sh_q, blank_sh_d;

  // Scan state.
  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [15:0]           frame_q, frame_d;

  // Registered pin drivers.
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;

  logic                  reg_wr;
  reg_e                  reg_sel;
  logic                  lit;
  logic [3:0]            nibble;
  logic [31:0]           ctrl_rd;
  logic [31:0]           status_rd;
  logic                  unused_bits;

  // Map a hex nibble to active-low GFEDCBA segments.
  function automatic logic [6:0] seg_decode(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h27;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  assign sel     = (addr[31:4] == BASE_ADDR[31:4]);
  assign reg_wr  = we && sel;
  assign reg_sel = reg_e'(addr[3:2]);
  // Byte-lane bits and the wdata bits beyond the register widths are not used.
  assign unused_bits = ^{addr[1:0], wdata};

  // Assemble the read views of CTRL and STATUS. Unused mask bits read as zero.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can leave it unassigned and infer a latch.
    ctrl_rd                     = '0;
    ctrl_rd[0]                  = en_q;
    ctrl_rd[8 +: NUM_DIGITS]    = dp_mask_q;
    ctrl_rd[16 +: NUM_DIGITS]   = blank_q;
    status_rd = {frame_q, 7'd0, (state_q == ST_GUARD), 5'd0, 3'(idx_q)};
  end

  // Combinational read mux. It returns zero outside the block and for the reserved slot.
  always_comb begin
    rdata = '0;
    if (sel) begin
      case (reg_sel)
        REG_DATA:   rdata = 32'(data_q);
        REG_CTRL:   rdata = ctrl_rd;
        REG_STATUS: rdata = status_rd;
        default:    rdata = '0;
      endcase
    end
  end

  // Bus writes to DATA and CTRL. STATUS and the reserved slot ignore writes.
  always_comb begin
    data_d    = data_q;
    en_d      = en_q;
    dp_mask_d = dp_mask_q;
    blank_d   = blank_q;
    if (reg_wr) begin
      case (reg_sel)
        REG_DATA: data_d = wdata[DATA_W-1:0];
        REG_CTRL: begin
          en_d      = wdata[0];
          dp_mask_d = wdata[8 +: NUM_DIGITS];
          blank_d   = wdata[16 +: NUM_DIGITS];
        end
        default: ;
      endcase
    end
  end

  // Scan sequencing. Shadows and the frame count update as digit 0 enters SHOW.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + 1'b1;
    idx_d      = idx_q;
    frame_d    = frame_q;
    data_sh_d  = data_sh_q;
    en_sh_d    = en_sh_q;
    dp_sh_d    = dp_sh_q;
    blank_sh_d = blank_sh_q;
    case (state_q)
      ST_GUARD: begin
        if (cnt_q == GUARD_LAST) begin
          state_d = ST_SHOW;
          cnt_d   = '0;
          if (idx_q == '0) begin
            // Shadows take the pre-edge live values. A write on this same edge shows next frame.
            data_sh_d  = data_q;
            en_sh_d    = en_q;
            dp_sh_d    = dp_mask_q;
            blank_sh_d = blank_q;
            frame_d    = frame_q + 16'd1;
          end
        end
      end
      default: begin
        if (cnt_q == SHOW_LAST) begin
          state_d = ST_GUARD;
          cnt_d   = '0;
          idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end
      end
    endcase
  end

  // Next pin values, computed from the current state so the pins lag the state by one cycle.
  always_comb begin
    nibble = data_sh_q[4*idx_q +: 4];
    lit    = (state_q == ST_SHOW) && en_sh_q && !blank_sh_q[idx_q];
    an_d   = '1;
    seg_d  = 7'h7F;
    dp_d   = 1'b1;
    if (lit) begin
      an_d[idx_q] = 1'b0;
      seg_d       = seg_decode(nibble);
      dp_d        = ~dp_sh_q[idx_q];
    end
  end

  // All state in one registered block. Synchronous reset leaves the display dark in GUARD.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_q     <= '0;
      en_q       <= 1'b0;
      dp_mask_q  <= '0;
      blank_q    <= '0;
      data_sh_q  <= '0;
      en_sh_q    <= 1'b0;
      dp_sh_q    <= '0;
      blank_sh_q <= '0;
      state_q    <= ST_GUARD;
      cnt_q      <= '0;
      idx_q      <= '0;
      frame_q    <= '0;
      an_q       <= '1;
      seg_q      <= 7'h7F;
      dp_q       <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments, so every flop samples pre-edge values regardless of statement order.
      data_q     <= data_d;
      en_q       <= en_d;
      dp_mask_q  <= dp_mask_d;
      blank_q    <= blank_d;
      data_sh_q  <= data_sh_d;
      en_sh_q    <= en_sh_d;
      dp_sh_q    <= dp_sh_d;
      blank_sh_q <= blank_sh_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      frame_q    <= frame_d;
      an_q       <= an_d;
      seg_q      <= seg_d;
      dp_q       <= dp_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;

endmodule
